// File: rtl/wshb_grid_writer.sv
// rtl/wshb_grid_writer.sv - Wishbone master that fills the framebuffer with a test grid
//
// Writes HDISP x VDISP 32-bit pixels with classic single-cycle writes and
// drops the bus for one cycle after every PKT acks so other masters get in.
//
// Ports:
//   wshb_clk, wshb_rst_n : clock, asynchronous active-low reset
//   enable               : level; start/continue frame writing
//   frame_done           : one-cycle pulse after the ack of the last pixel
//   wshb_cyc/stb/we/sel/cti/bte/adr/dat_ms : wishbone master outputs
//   wshb_ack, wshb_dat_sm                  : wishbone slave inputs
module wshb_grid_writer #(
  parameter int          HDISP = 800,
  parameter int          VDISP = 480,
  parameter int          GRID  = 16,
  parameter int          PKT   = 64,
  parameter logic [31:0] FG    = 32'h00FFFFFF,
  parameter logic [31:0] BG    = 32'h00000000
) (
  input  logic        wshb_clk,
  input  logic        wshb_rst_n,
  input  logic        enable,
  output logic        frame_done,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [3:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  output logic [31:0] wshb_adr,
  output logic [31:0] wshb_dat_ms,
  input  logic        wshb_ack,
  input  logic [31:0] wshb_dat_sm
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int PW = (PKT > 1) ? $clog2(PKT) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PKT - 1);
  // GRID is a power of two, so "mod GRID" is a mask of the low bits.
  localparam logic [31:0]   GMASK  = 32'(GRID - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_PAUSE} state_t;

  state_t        state, state_next;
  logic [XW-1:0] x, x_next;
  logic [YW-1:0] y, y_next;
  logic [PW-1:0] pkt, pkt_next;
  logic [31:0]   adr_next;
  logic [31:0]   pix_next;
  logic          x_end, y_end, frame_end, pkt_end, beat;

  assign wshb_stb = wshb_cyc;
  assign wshb_we  = 1'b1;
  assign wshb_sel = 4'b1111;
  assign wshb_cti = 3'b000;
  assign wshb_bte = 2'b00;

  logic unused_dat_sm;
  assign unused_dat_sm = ^wshb_dat_sm;

  assign x_end     = (x == X_LAST);
  assign y_end     = (y == Y_LAST);
  assign frame_end = x_end & y_end;
  assign pkt_end   = (pkt == P_LAST);
  assign beat      = (state == S_WRITE) & wshb_ack;

  always_comb begin
    state_next = state;
    x_next     = x;
    y_next     = y;
    pkt_next   = pkt;
    adr_next   = wshb_adr;
    case (state)
      S_IDLE: begin
        if (enable) state_next = S_WRITE;
      end
      S_WRITE: begin
        if (wshb_ack) begin
          x_next   = x_end ? '0 : x + 1'b1;
          y_next   = x_end ? (y_end ? '0 : y + 1'b1) : y;
          adr_next = frame_end ? 32'd0 : wshb_adr + 32'd4;
          if (frame_end || pkt_end) begin
            pkt_next   = '0;
            state_next = S_PAUSE;
          end else begin
            pkt_next = pkt + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        // frame_done is high exactly during the pause that follows a frame end.
        state_next = (frame_done && !enable) ? S_IDLE : S_WRITE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Pixel colour of the pixel that will be on the bus next.
  always_comb begin
    pix_next = BG;
    if (((32'(x_next) & GMASK) == 32'd0) || ((32'(y_next) & GMASK) == 32'd0))
      pix_next = FG;
  end

  always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
    if (!wshb_rst_n) begin
      state       <= S_IDLE;
      x           <= '0;
      y           <= '0;
      pkt         <= '0;
      wshb_cyc    <= 1'b0;
      wshb_adr    <= 32'd0;
      wshb_dat_ms <= 32'd0;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_next;
      x          <= x_next;
      y          <= y_next;
      pkt        <= pkt_next;
      wshb_adr   <= adr_next;
      wshb_cyc   <= (state_next == S_WRITE);
      frame_done <= beat & frame_end;
      if (state_next == S_WRITE) wshb_dat_ms <= pix_next;
    end
  end

endmodule
